// File: rtl/reg2tl_if.sv
// TileLink-UL channel payload types and the bundled request/TL port of the reg2tl bridge.
// The package lives here so the interface and the bridge share one definition.
package tl_pkg;
  localparam logic [2:0] PutFullData   = 3'h0;
  localparam logic [2:0] Get           = 3'h4;
  localparam logic [2:0] AccessAck     = 3'h0;
  localparam logic [2:0] AccessAckData = 3'h1;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [2:0]  size;
    logic [7:0]  source;
    logic [63:0] address;
    logic [7:0]  mask;
    logic [63:0] data;
    logic        corrupt;
  } A_chan_bits_t;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  param;
    logic [2:0]  size;
    logic [7:0]  source;
    logic [0:0]  sink;
    logic        denied;
    logic [63:0] data;
    logic        corrupt;
  } D_chan_bits_t;
endpackage

interface reg2tl_if #(
  parameter int ADDR_WIDTH = 64
);
  logic                    en_i;
  logic                    we_i;
  logic [ADDR_WIDTH-1:0]   addr_i;
  logic [31:0]             wdata_i;
  logic                    gnt_o;
  logic                    rvalid_o;
  logic [31:0]             rdata_o;
  logic                    err_o;
  logic                    busy_o;
  logic                    TL_A_valid_o;
  logic                    TL_A_ready_i;
  tl_pkg::A_chan_bits_t    TL_A_bits_o;
  logic                    TL_D_valid_i;
  logic                    TL_D_ready_o;
  tl_pkg::D_chan_bits_t    TL_D_bits_i;

  // master: CSR requester plus TileLink fabric; slave: the bridge itself
  modport master (
    output en_i, we_i, addr_i, wdata_i, TL_A_ready_i, TL_D_valid_i, TL_D_bits_i,
    input  gnt_o, rvalid_o, rdata_o, err_o, busy_o, TL_A_valid_o, TL_A_bits_o, TL_D_ready_o
  );

  modport slave (
    input  en_i, we_i, addr_i, wdata_i, TL_A_ready_i, TL_D_valid_i, TL_D_bits_i,
    output gnt_o, rvalid_o, rdata_o, err_o, busy_o, TL_A_valid_o, TL_A_bits_o, TL_D_ready_o
  );
endinterface

// File: rtl/reg2tl.sv
// Register-bus to TileLink-UL initiator bridge: one 32-bit access outstanding on a 64-bit A/D
// channel pair, with a response timeout and draining of the late D beat that follows a timeout.
module reg2tl #(
  parameter int ADDR_WIDTH = 64,
  parameter int SOURCE_ID  = 0,
  parameter int TIMEOUT    = 1024
) (
  input  logic     clk_i,
  input  logic     rst_i,
  reg2tl_if.slave  bus
);
  import tl_pkg::*;

  typedef enum logic [1:0] {IDLE, SEND_A, WAIT_D, RESP} state_e;

  state_e       state_q, state_d;
  A_chan_bits_t a_q, a_d;
  logic [31:0]  rdata_q, rdata_d;
  logic         err_q, err_d;
  logic         stale_q, stale_d;
  logic [15:0]  cnt_q, cnt_d;
  logic         gnt, a_valid;
  logic         d_fire, src_match, d_err;
  logic         unused_d;

  assign d_fire    = bus.TL_D_valid_i;
  assign src_match = bus.TL_D_bits_i.source == 8'(SOURCE_ID);
  assign d_err     = bus.TL_D_bits_i.denied | bus.TL_D_bits_i.corrupt;
  assign unused_d  = ^{bus.TL_D_bits_i.opcode, bus.TL_D_bits_i.param,
                       bus.TL_D_bits_i.size, bus.TL_D_bits_i.sink};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      stale_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      stale_q <= stale_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    stale_d = stale_q;
    cnt_d   = cnt_q;
    gnt     = 1'b0;
    a_valid = 1'b0;

    // The first matching beat after a timeout is the late answer to the abandoned request.
    if (stale_q && d_fire && src_match) stale_d = 1'b0;

    case (state_q)
      IDLE: begin
        gnt = bus.en_i;
        if (bus.en_i) begin
          if (bus.addr_i[1:0] != 2'b00) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = RESP;
          end else begin
            a_d.opcode  = bus.we_i ? PutFullData : Get;
            a_d.param   = '0;
            a_d.size    = 3'd2;
            a_d.source  = 8'(SOURCE_ID);
            a_d.address = 64'({bus.addr_i[ADDR_WIDTH-1:2], 2'b00});
            a_d.mask    = bus.addr_i[2] ? 8'hF0 : 8'h0F;
            a_d.data    = bus.addr_i[2] ? {bus.wdata_i, 32'h0} : {32'h0, bus.wdata_i};
            a_d.corrupt = 1'b0;
            state_d     = SEND_A;
          end
        end
      end
      SEND_A: begin
        a_valid = 1'b1;
        if (bus.TL_A_ready_i) begin
          cnt_d   = '0;
          state_d = WAIT_D;
        end
      end
      WAIT_D: begin
        if (d_fire && src_match && !stale_q) begin
          err_d = d_err;
          if (a_q.opcode == PutFullData || d_err) rdata_d = '0;
          else rdata_d = a_q.address[2] ? bus.TL_D_bits_i.data[63:32]
                                        : bus.TL_D_bits_i.data[31:0];
          state_d = RESP;
        end else if (TIMEOUT != 0 && cnt_q == 16'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          rdata_d = '0;
          stale_d = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // D is always accepted: beats are either consumed, drained as stale, or dropped as spurious.
  assign bus.gnt_o        = gnt;
  assign bus.rvalid_o     = state_q == RESP;
  assign bus.rdata_o      = rdata_q;
  assign bus.err_o        = err_q;
  assign bus.busy_o       = state_q != IDLE;
  assign bus.TL_A_valid_o = a_valid;
  assign bus.TL_A_bits_o  = a_q;
  assign bus.TL_D_ready_o = 1'b1;
endmodule

// File: tb/tb_reg2tl.sv
// Directed self-checking bench for reg2tl: aligned read/write, A backpressure, misalignment,
// denied response, foreign source, timeout with stale drain, and reset mid-transaction.
module tb_reg2tl;
  import tl_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i;
  int   checks = 0;
  int   errors = 0;

  always #5 clk_i = ~clk_i;

  reg2tl_if #(.ADDR_WIDTH(64)) bus ();

  reg2tl #(.ADDR_WIDTH(64), .SOURCE_ID(5), .TIMEOUT(8)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic cyc();
    @(negedge clk_i);
  endtask

  task automatic applyStimulus(input logic en, input logic we, input logic [63:0] addr,
                               input logic [31:0] wdata);
    bus.en_i    = en;
    bus.we_i    = we;
    bus.addr_i  = addr;
    bus.wdata_i = wdata;
  endtask

  task automatic driveD(input logic valid, input logic [7:0] src, input logic denied,
                        input logic [63:0] data, input logic [2:0] op);
    bus.TL_D_valid_i         = valid;
    bus.TL_D_bits_i          = '0;
    bus.TL_D_bits_i.opcode   = op;
    bus.TL_D_bits_i.size     = 3'd2;
    bus.TL_D_bits_i.source   = src;
    bus.TL_D_bits_i.denied   = denied;
    bus.TL_D_bits_i.data     = data;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_i = 1'b1;
    applyStimulus(0, 0, 0, 0);
    bus.TL_A_ready_i = 1'b0;
    driveD(0, 0, 0, 0, AccessAck);
    repeat (2) cyc();
    #1;
    checkOutput("rst_gnt", bus.gnt_o, 0);
    checkOutput("rst_rvalid", bus.rvalid_o, 0);
    checkOutput("rst_busy", bus.busy_o, 0);
    checkOutput("rst_avalid", bus.TL_A_valid_o, 0);
    checkOutput("rst_rdata", bus.rdata_o, 0);
    checkOutput("rst_err", bus.err_o, 0);
    checkOutput("rst_dready", bus.TL_D_ready_o, 1);
    checkOutput("rst_abits_zero", bus.TL_A_bits_o == '0, 1);
    cyc();
    rst_i = 1'b0;

    // Aligned read of the upper word, best-case latency
    cyc(); applyStimulus(1, 0, 64'h1000_0004, 0); #1;
    checkOutput("rd_gnt", bus.gnt_o, 1);
    cyc(); applyStimulus(0, 0, 0, 0); bus.TL_A_ready_i = 1'b1; #1;
    checkOutput("rd_gnt_low", bus.gnt_o, 0);
    checkOutput("rd_busy", bus.busy_o, 1);
    checkOutput("rd_avalid", bus.TL_A_valid_o, 1);
    checkOutput("rd_opcode", bus.TL_A_bits_o.opcode, Get);
    checkOutput("rd_mask", bus.TL_A_bits_o.mask, 8'hF0);
    checkOutput("rd_address", bus.TL_A_bits_o.address, 64'h1000_0004);
    checkOutput("rd_size", bus.TL_A_bits_o.size, 2);
    checkOutput("rd_source", bus.TL_A_bits_o.source, 5);
    cyc(); bus.TL_A_ready_i = 1'b0;
    driveD(1, 5, 0, 64'h1122_3344_5566_7788, AccessAckData); #1;
    checkOutput("rd_avalid_drop", bus.TL_A_valid_o, 0);
    checkOutput("rd_rvalid_early", bus.rvalid_o, 0);
    cyc(); driveD(0, 0, 0, 0, AccessAck); #1;
    checkOutput("rd_rvalid", bus.rvalid_o, 1);
    checkOutput("rd_rdata", bus.rdata_o, 32'h1122_3344);
    checkOutput("rd_err", bus.err_o, 0);
    cyc(); #1;
    checkOutput("rd_rvalid_pulse", bus.rvalid_o, 0);
    checkOutput("rd_idle", bus.busy_o, 0);

    // Write with A backpressure; inputs change after grant to prove the payload is registered
    cyc(); applyStimulus(1, 1, 64'h2000_0000, 32'hDEAD_BEEF); #1;
    checkOutput("wr_gnt", bus.gnt_o, 1);
    cyc(); applyStimulus(0, 0, 64'h7777_0004, 32'h1234_5678);
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput("wr_hold_valid", bus.TL_A_valid_o, 1);
      checkOutput("wr_hold_data", bus.TL_A_bits_o.data, 64'h0000_0000_DEAD_BEEF);
      checkOutput("wr_hold_mask", bus.TL_A_bits_o.mask, 8'h0F);
      checkOutput("wr_hold_opcode", bus.TL_A_bits_o.opcode, PutFullData);
      checkOutput("wr_hold_addr", bus.TL_A_bits_o.address, 64'h2000_0000);
      cyc();
    end
    bus.TL_A_ready_i = 1'b1; #1;
    checkOutput("wr_valid_at_fire", bus.TL_A_valid_o, 1);
    cyc(); bus.TL_A_ready_i = 1'b0;
    driveD(1, 5, 0, 64'hFFFF_FFFF_FFFF_FFFF, AccessAck);
    cyc(); driveD(0, 0, 0, 0, AccessAck); #1;
    checkOutput("wr_rvalid", bus.rvalid_o, 1);
    checkOutput("wr_rdata", bus.rdata_o, 0);
    checkOutput("wr_err", bus.err_o, 0);

    // Misaligned read: error on the cycle after grant, no A traffic
    cyc(); applyStimulus(1, 0, 64'h3, 0); #1;
    checkOutput("mis_gnt", bus.gnt_o, 1);
    checkOutput("mis_avalid0", bus.TL_A_valid_o, 0);
    cyc(); applyStimulus(0, 0, 0, 0); #1;
    checkOutput("mis_rvalid", bus.rvalid_o, 1);
    checkOutput("mis_err", bus.err_o, 1);
    checkOutput("mis_rdata", bus.rdata_o, 0);
    checkOutput("mis_avalid1", bus.TL_A_valid_o, 0);
    cyc(); #1;
    checkOutput("mis_rvalid_pulse", bus.rvalid_o, 0);
    checkOutput("mis_avalid2", bus.TL_A_valid_o, 0);

    // Foreign-source beat dropped, then denied response
    cyc(); applyStimulus(1, 0, 64'h8, 0);
    cyc(); applyStimulus(0, 0, 0, 0); bus.TL_A_ready_i = 1'b1;
    cyc(); bus.TL_A_ready_i = 1'b0; driveD(1, 2, 0, 64'h1234, AccessAckData);
    cyc(); driveD(1, 5, 1, 64'hFFFF_FFFF_FFFF_FFFF, AccessAckData); #1;
    checkOutput("den_foreign_dropped", bus.rvalid_o, 0);
    cyc(); driveD(0, 0, 0, 0, AccessAck); #1;
    checkOutput("den_rvalid", bus.rvalid_o, 1);
    checkOutput("den_err", bus.err_o, 1);
    checkOutput("den_rdata", bus.rdata_o, 0);

    // Timeout: completion 9 cycles after A fire, then the late beat is drained
    cyc(); applyStimulus(1, 0, 64'h40, 0);
    cyc(); applyStimulus(0, 0, 0, 0); bus.TL_A_ready_i = 1'b1;
    cyc(); bus.TL_A_ready_i = 1'b0;
    for (int i = 2; i < 10; i++) begin
      #1;
      checkOutput("to_wait", bus.rvalid_o, 0);
      cyc();
    end
    #1;
    checkOutput("to_rvalid", bus.rvalid_o, 1);
    checkOutput("to_err", bus.err_o, 1);
    checkOutput("to_rdata", bus.rdata_o, 0);
    cyc(); applyStimulus(1, 0, 64'h50, 0); #1;
    checkOutput("st_gnt", bus.gnt_o, 1);
    cyc(); applyStimulus(0, 0, 0, 0); bus.TL_A_ready_i = 1'b1;
    cyc(); bus.TL_A_ready_i = 1'b0; driveD(1, 5, 0, 64'hAAAA, AccessAckData); #1;
    checkOutput("st_dready", bus.TL_D_ready_o, 1);
    cyc(); driveD(1, 5, 0, 64'h0000_0000_0000_0055, AccessAckData); #1;
    checkOutput("st_stale_dropped", bus.rvalid_o, 0);
    cyc(); driveD(0, 0, 0, 0, AccessAck); #1;
    checkOutput("st_rvalid", bus.rvalid_o, 1);
    checkOutput("st_rdata", bus.rdata_o, 32'h55);
    checkOutput("st_err", bus.err_o, 0);

    // Reset while waiting for D, then a clean read
    cyc(); applyStimulus(1, 0, 64'h4, 0);
    cyc(); applyStimulus(0, 0, 0, 0); bus.TL_A_ready_i = 1'b1;
    cyc(); bus.TL_A_ready_i = 1'b0; #1;
    checkOutput("mr_busy_before", bus.busy_o, 1);
    rst_i = 1'b1; #1;
    checkOutput("mr_busy", bus.busy_o, 0);
    checkOutput("mr_rvalid", bus.rvalid_o, 0);
    checkOutput("mr_avalid", bus.TL_A_valid_o, 0);
    checkOutput("mr_rdata", bus.rdata_o, 0);
    checkOutput("mr_err", bus.err_o, 0);
    checkOutput("mr_abits_zero", bus.TL_A_bits_o == '0, 1);
    checkOutput("mr_dready", bus.TL_D_ready_o, 1);
    cyc(); rst_i = 1'b0;
    cyc(); applyStimulus(1, 0, 64'h4, 0); #1;
    checkOutput("pr_gnt", bus.gnt_o, 1);
    cyc(); applyStimulus(0, 0, 0, 0); bus.TL_A_ready_i = 1'b1;
    cyc(); bus.TL_A_ready_i = 1'b0; driveD(1, 5, 0, 64'hCAFE_F00D_1234_5678, AccessAckData);
    cyc(); driveD(0, 0, 0, 0, AccessAck); #1;
    checkOutput("pr_rvalid", bus.rvalid_o, 1);
    checkOutput("pr_rdata", bus.rdata_o, 32'hCAFE_F00D);
    checkOutput("pr_err", bus.err_o, 0);

    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg2tl.md
# reg2tl

Register-bus-to-TileLink initiator bridge. Accepts single 32-bit register reads/writes from a simple `en/we` request port and issues TileLink-UL `Get`/`PutFullData` on a 64-bit A channel. It returns the D-channel response as a one-cycle `rvalid_o` pulse. It sits between a CSR-style master (debug module, boot ROM loader) and the TileLink crossbar, and allows one transaction outstanding.

## Interface
- ADDR_WIDTH, 64, request/TL address width
- SOURCE_ID, 0, value driven on `TL_A_bits_o.source`; D beats with another source are ignored
- TIMEOUT, 1024, cycles waited for D before an error completion; 0 disables; legal range 0..65535

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  asynchronous, active-high reset
- en_i  in  1  request valid; held stable until `gnt_o`
- we_i  in  1  1 = write, 0 = read
- addr_i  in  ADDR_WIDTH  byte address
- wdata_i  in  32  write data
- gnt_o  out  1  request accepted this cycle
- rvalid_o  out  1  one-cycle completion pulse
- rdata_o  out  32  read data, valid with `rvalid_o`; 0 for writes and errors
- err_o  out  1  completion error, valid with `rvalid_o`
- busy_o  out  1  state != IDLE
- TL_A_valid_o  out  1  A valid
- TL_A_ready_i  in  1  A ready
- TL_A_bits_o  out  tl_pkg::A_chan_bits_t  A payload
- TL_D_valid_i  in  1  D valid
- TL_D_ready_o  out  1  D ready
- TL_D_bits_i  in  tl_pkg::D_chan_bits_t  D payload

## Operation
- FSM states: IDLE, SEND_A, WAIT_D, RESP. Reset state is IDLE.
- IDLE:
  - `gnt_o = en_i`.
  - On `en_i`, capture we, addr, and wdata.
  - If `addr_i[1:0] != 0`, go to RESP with err=1 and issue no TL traffic.
  - Otherwise go to SEND_A.
- SEND_A:
  - `TL_A_valid_o = 1`. Payload comes from registers and is stable until `TL_A_ready_i`.
  - On A fire, go to WAIT_D and clear the timeout counter.
- A payload:
  - opcode = PutFullData if we, else Get.
  - param = 0.
  - size = 2.
  - source = SOURCE_ID.
  - address = addr with [1:0] forced to 0.
  - mask = addr[2] ? 8'hF0 : 8'h0F.
  - data = addr[2] ? {wdata, 32'h0} : {32'h0, wdata}.
  - corrupt = 0.
- WAIT_D:
  - `TL_D_ready_o = 1`.
  - On D fire with source == SOURCE_ID and stale_q == 0:
    - Capture rdata = addr[2] ? data[63:32] : data[31:0]. Force 0 if write or error.
    - Capture err = denied | corrupt.
    - Go to RESP.
  - A non-matching source is accepted and dropped; the state is unchanged.
  - The counter increments each cycle without D fire. When the counter reaches TIMEOUT-1 (TIMEOUT≠0), go to RESP with err=1 and set stale_q.
- RESP: `rvalid_o = 1` for exactly one cycle with `rdata_o`/`err_o` from registers, then go to IDLE.
- Stale drain:
  - While stale_q = 1, `TL_D_ready_o = 1` in every state.
  - The first D fire with source == SOURCE_ID is dropped and clears stale_q.
  - A new request may proceed meanwhile. Its D is distinguished because the stale response arrives first (single source, in-order).
- In IDLE/SEND_A/RESP with stale_q = 0, `TL_D_ready_o = 1`, and any D beat is dropped as spurious.
- Reset mid-transaction: return to IDLE, drop the transaction, and clear stale_q. No completion is produced.

## Timing
- Reset values: gnt_o, rvalid_o, err_o, busy_o, TL_A_valid_o = 0; rdata_o = 0; TL_A_bits_o = all zero; TL_D_ready_o = 1 (IDLE).
- `gnt_o` is combinational from `en_i` in IDLE. It is 0 in all other states.
- Best case, aligned access:
  - Cycle 0: gnt.
  - Cycle 1: A valid (fires if ready).
  - Cycle 2: D may fire.
  - Cycle 3: rvalid.
  - Total: 3 cycles from gnt to rvalid.
- Misaligned: rvalid/err on cycle 1 after gnt.
- Next request is accepted no earlier than the cycle after RESP, giving a minimum issue interval of 4 cycles.
- A-channel rule: once TL_A_valid_o rises, it and its payload hold until ready. There is no retraction.
- Timeout: with no D, rvalid/err is asserted TIMEOUT+1 cycles after A fire.

## Test plan
- Read addr=0x1000_0004, D data=0x1122_3344_5566_7788 on cycle 2 -> A: Get, mask 0xF0, address 0x1000_0004. Response: rvalid on cycle 3, rdata=0x1122_3344, err=0.
- Write addr=0x2000_0000, wdata=0xDEAD_BEEF, A_ready low for 5 cycles -> A payload stable throughout with data 0x0000_0000_DEAD_BEEF and mask 0x0F. Response: AccessAck gives rvalid with rdata=0, err=0.
- Read addr=0x3 -> gnt, then rvalid+err on the next cycle, with no TL_A_valid_o ever.
- Read with D denied=1, data=0xFFFF... -> rvalid, err=1, rdata=0.
- TIMEOUT=8, D withheld -> err completion 9 cycles after A fire.
  - A new read is issued, then a late D (data 0xAAAA) arrives first and is dropped.
  - The following D (data 0x0000_0000_0000_0055, addr[2]=0) yields rdata=0x55.
- Assert rst_i in WAIT_D -> next cycle all outputs at reset values and busy_o=0. A subsequent read completes normally.
